// File: rtl/wbvio_cmd_sequencer.sv
// Command sequencer in front of wbvio_bridge: a FIFO of single-word WISHBONE commands, one go/done
// handshake per command, and one read-data/err/timeout response per command.
module wbvio_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH_LOG2 = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GO_LOW_CYCLES  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic                      cmd_lock_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_dat_i,
  output logic [CMD_DEPTH_LOG2:0]   cmd_count_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [ADDR_WIDTH-1:0]     seq_adr_o,
  output logic [DATA_WIDTH-1:0]     seq_dat_o,
  output logic                      seq_we_o,
  output logic                      seq_lock_o,
  output logic                      seq_go_o,
  input  logic [DATA_WIDTH-1:0]     seq_dat_i,
  input  logic                      seq_done_i,
  input  logic                      seq_err_i
);

  localparam int         DEPTH     = 1 << CMD_DEPTH_LOG2;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);
  localparam logic [7:0] GO_LOW_C  = 8'(GO_LOW_CYCLES);

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_RELEASE, S_RESP} state_t;

  state_t                  state_q, state_d;
  cmd_t                    mem [DEPTH];
  cmd_t                    head;
  logic [CMD_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CMD_DEPTH_LOG2:0] count_q;
  logic                    full, empty, push, pop;
  logic [7:0]              cnt_q, cnt_inc;

  logic [ADDR_WIDTH-1:0]   seq_adr_q;
  logic [DATA_WIDTH-1:0]   seq_dat_q, rsp_dat_q;
  logic                    seq_we_q, seq_lock_q, seq_go_q;
  logic                    rsp_valid_q, rsp_err_q, rsp_timeout_q;

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full  = count_q[CMD_DEPTH_LOG2];
  assign empty = (count_q == '0);
  assign push  = cmd_valid_i && !full;
  assign head  = mem[rd_ptr_q];

  // NOTE: FIFO storage has no reset; only the pointers and count need one to make it empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= '{we: cmd_we_i, lock: cmd_lock_i, adr: cmd_adr_i, dat: cmd_dat_i};
  end

  // NOTE: state and registers use non-blocking assignments; only always_comb uses blocking ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CMD_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + CMD_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (CMD_DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (CMD_DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Shared cycle counter: WAIT timeout, then go-low time in RELEASE. Saturates at 255.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_WAIT;
      S_WAIT: begin
        if (seq_err_i || seq_done_i || cnt_inc == TIMEOUT_C) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (cnt_inc >= GO_LOW_C && !seq_done_i && !seq_err_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_adr_q     <= '0;
      seq_dat_q     <= '0;
      seq_we_q      <= 1'b0;
      seq_lock_q    <= 1'b0;
      seq_go_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            seq_adr_q  <= head.adr;
            seq_dat_q  <= head.dat;
            seq_we_q   <= head.we;
            seq_lock_q <= head.lock;
          end
        end
        S_SETUP: begin
          seq_go_q <= 1'b1;
          cnt_q    <= '0;
        end
        S_WAIT: begin
          cnt_q <= cnt_inc;
          // err has priority over done; timeout only when the bridge stayed silent.
          if (seq_err_i) begin
            rsp_err_q <= 1'b1;
            rsp_dat_q <= seq_dat_i;
          end else if (seq_done_i) begin
            rsp_dat_q <= seq_dat_i;
          end else if (cnt_inc == TIMEOUT_C) begin
            rsp_timeout_q <= 1'b1;
            rsp_dat_q     <= '0;
            seq_lock_q    <= 1'b0;
          end
          if (state_d == S_RELEASE) begin
            seq_go_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_RELEASE: begin
          cnt_q <= cnt_inc;
          if (state_d == S_RESP) rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o   = !full;
  assign cmd_count_o   = count_q;
  assign busy_o        = (state_q != S_IDLE);
  assign seq_adr_o     = seq_adr_q;
  assign seq_dat_o     = seq_dat_q;
  assign seq_we_o      = seq_we_q;
  assign seq_lock_o    = seq_lock_q;
  assign seq_go_o      = seq_go_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
